// File: rtl/lsu_port_arbiter.sv
// ---------------------------------------------------------------------------
// lsu_port_arbiter
//
// Shares one Ibex-style LSU memory port (req/gnt/rvalid) between N_REQ
// requesters. Round-robin arbitration picks a winner each cycle. Once a
// request has been presented downstream without a grant, the winner is locked
// until that request is granted. An in-order ID FIFO records who issued each
// granted transaction, so every downstream response can be routed back.
// There are no datapath registers, so grants and responses pass through in
// the same cycle.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   s_req_i         per-requester request
//   s_addr_i        packed addresses, requester k at [32k+31:32k]
//   s_we_i          per-requester write enable
//   s_be_i          packed byte enables, requester k at [4k+3:4k]
//   s_wdata_i       packed write data, requester k at [32k+31:32k]
//   s_gnt_o         grant back to the winner (one-hot or zero)
//   s_rvalid_o      response valid to the issuing requester (one-hot or zero)
//   s_err_o         response error, broadcast, qualified by s_rvalid_o
//   s_rdata_o       response read data, broadcast
//   m_req_o .. m_wdata_o   downstream request channel
//   m_gnt_i         downstream grant
//   m_rvalid_i, m_err_i, m_rdata_i   downstream response channel
//   outst_o         number of granted transactions awaiting a response
//   proto_err_o     sticky: a response arrived with nothing outstanding
// ---------------------------------------------------------------------------
module lsu_port_arbiter #(
    parameter int N_REQ     = 2,
    parameter int MAX_OUTST = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,

    input  logic [N_REQ-1:0]               s_req_i,
    input  logic [N_REQ*32-1:0]            s_addr_i,
    input  logic [N_REQ-1:0]               s_we_i,
    input  logic [N_REQ*4-1:0]             s_be_i,
    input  logic [N_REQ*32-1:0]            s_wdata_i,
    output logic [N_REQ-1:0]               s_gnt_o,
    output logic [N_REQ-1:0]               s_rvalid_o,
    output logic                           s_err_o,
    output logic [31:0]                    s_rdata_o,

    output logic                           m_req_o,
    output logic [31:0]                    m_addr_o,
    output logic                           m_we_o,
    output logic [3:0]                     m_be_o,
    output logic [31:0]                    m_wdata_o,
    input  logic                           m_gnt_i,
    input  logic                           m_rvalid_i,
    input  logic                           m_err_i,
    input  logic [31:0]                    m_rdata_i,

    output logic [$clog2(MAX_OUTST+1)-1:0] outst_o,
    output logic                           proto_err_o
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    // Arbitration state
    logic [IDX_W-1:0] rr_ptr;
    logic             lock_q;
    logic [IDX_W-1:0] lock_idx_q;

    // ID FIFO state
    logic [IDX_W-1:0] fifo_mem [MAX_OUTST];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic             proto_err_q;

    // Per-requester views of the packed request buses
    logic [31:0]      addr_arr  [N_REQ];
    logic [31:0]      wdata_arr [N_REQ];
    logic [3:0]       be_arr    [N_REQ];

    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic             any_req;
    logic             fifo_full;
    logic             fifo_empty;
    logic             grant;
    logic             pop;
    logic [IDX_W-1:0] head_idx;

    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            addr_arr[k]  = s_addr_i[32*k +: 32];
            wdata_arr[k] = s_wdata_i[32*k +: 32];
            be_arr[k]    = s_be_i[4*k +: 4];
        end
    end

    // Winner: the locked requester if a lock is held, otherwise the first
    // requester at or after rr_ptr. Scanning offsets from the far end down
    // lets the closest requester overwrite any later candidate.
    always_comb begin
        int k;
        win_found = 1'b0;
        win_idx   = '0;
        k         = 0;
        if (lock_q) begin
            win_found = 1'b1;
            win_idx   = lock_idx_q;
        end else begin
            for (int i = N_REQ - 1; i >= 0; i--) begin
                k = int'(rr_ptr) + i;
                if (k >= N_REQ) begin
                    k = k - N_REQ;
                end
                if (s_req_i[IDX_W'(k)]) begin
                    win_found = 1'b1;
                    win_idx   = IDX_W'(k);
                end
            end
        end
    end

    assign fifo_full  = (count_q == CNT_W'(MAX_OUTST));
    assign fifo_empty = (count_q == '0);

    // lock_q alone keeps the request alive if a locked requester drops its
    // request. rst_n keeps the port quiet while reset is held, even when
    // requesters are still asserting.
    assign any_req = rst_n && (lock_q || (|s_req_i));
    assign m_req_o = any_req && !fifo_full;
    assign grant   = m_req_o && m_gnt_i;

    assign m_addr_o  = win_found ? addr_arr[win_idx]  : 32'h0;
    assign m_we_o    = win_found ? s_we_i[win_idx]    : 1'b0;
    assign m_be_o    = win_found ? be_arr[win_idx]    : 4'h0;
    assign m_wdata_o = win_found ? wdata_arr[win_idx] : 32'h0;

    always_comb begin
        s_gnt_o = '0;
        if (grant) begin
            s_gnt_o[win_idx] = 1'b1;
        end
    end

    // Responses are in order, so the FIFO head always names the owner.
    assign head_idx = fifo_mem[rd_ptr_q];
    assign pop      = m_rvalid_i && !fifo_empty;

    always_comb begin
        s_rvalid_o = '0;
        if (pop) begin
            s_rvalid_o[head_idx] = 1'b1;
        end
    end

    assign s_rdata_o   = m_rdata_i;
    assign s_err_o     = m_err_i;
    assign outst_o     = count_q;
    assign proto_err_o = proto_err_q;

    // Control state: arbitration pointer, lock, FIFO pointers/count, error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            lock_q      <= 1'b0;
            lock_idx_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            if (grant) begin
                lock_q   <= 1'b0;
                rr_ptr   <= (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;
                wr_ptr_q <= (wr_ptr_q == PTR_W'(MAX_OUTST - 1)) ? '0 : wr_ptr_q + 1'b1;
            end else if (m_req_o) begin
                lock_q     <= 1'b1;
                lock_idx_q <= win_idx;
            end

            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(MAX_OUTST - 1)) ? '0 : rd_ptr_q + 1'b1;
            end

            // A push and pop together leave the count unchanged.
            case ({grant, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            if (m_rvalid_i && fifo_empty) begin
                proto_err_q <= 1'b1;
            end
        end
    end

    // FIFO storage holds only requester IDs; its contents are meaningless
    // until the pointers say otherwise, so it is not reset.
    always_ff @(posedge clk) begin
        if (grant) begin
            fifo_mem[wr_ptr_q] <= win_idx;
        end
    end

endmodule

// File: tb/tb_lsu_port_arbiter.sv
module tb_lsu_port_arbiter;

    localparam int N_REQ     = 2;
    localparam int MAX_OUTST = 2;
    localparam int CNT_W     = $clog2(MAX_OUTST + 1);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N_REQ-1:0]     s_req_i;
    logic [N_REQ*32-1:0]  s_addr_i;
    logic [N_REQ-1:0]     s_we_i;
    logic [N_REQ*4-1:0]   s_be_i;
    logic [N_REQ*32-1:0]  s_wdata_i;
    logic [N_REQ-1:0]     s_gnt_o;
    logic [N_REQ-1:0]     s_rvalid_o;
    logic                 s_err_o;
    logic [31:0]          s_rdata_o;
    logic                 m_req_o;
    logic [31:0]          m_addr_o;
    logic                 m_we_o;
    logic [3:0]           m_be_o;
    logic [31:0]          m_wdata_o;
    logic                 m_gnt_i;
    logic                 m_rvalid_i;
    logic                 m_err_i;
    logic [31:0]          m_rdata_i;
    logic [CNT_W-1:0]     outst_o;
    logic                 proto_err_o;

    lsu_port_arbiter #(.N_REQ(N_REQ), .MAX_OUTST(MAX_OUTST)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_req_i     (s_req_i),
        .s_addr_i    (s_addr_i),
        .s_we_i      (s_we_i),
        .s_be_i      (s_be_i),
        .s_wdata_i   (s_wdata_i),
        .s_gnt_o     (s_gnt_o),
        .s_rvalid_o  (s_rvalid_o),
        .s_err_o     (s_err_o),
        .s_rdata_o   (s_rdata_o),
        .m_req_o     (m_req_o),
        .m_addr_o    (m_addr_o),
        .m_we_o      (m_we_o),
        .m_be_o      (m_be_o),
        .m_wdata_o   (m_wdata_o),
        .m_gnt_i     (m_gnt_i),
        .m_rvalid_i  (m_rvalid_i),
        .m_err_i     (m_err_i),
        .m_rdata_i   (m_rdata_i),
        .outst_o     (outst_o),
        .proto_err_o (proto_err_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Fixed-address drive used by the vector table and hand sequences.
    task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                         input logic err, input logic [31:0] rdata);
        s_req_i    = req;
        s_addr_i   = {32'h0000_0200, 32'h0000_0100};
        s_we_i     = 2'b00;
        s_be_i     = 8'hFF;
        s_wdata_i  = '0;
        m_gnt_i    = gnt;
        m_rvalid_i = rv;
        m_err_i    = err;
        m_rdata_i  = rdata;
    endtask

    typedef struct {
        logic [1:0]       req;
        logic             gnt;
        logic             rv;
        logic             err;
        logic [31:0]      rdata;
        logic             e_mreq;
        logic [31:0]      e_addr;
        logic [1:0]       e_gnt;
        logic [1:0]       e_rv;
        logic [CNT_W-1:0] e_outst;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [1:0] req, input logic gnt, input logic rv,
                                input logic err, input logic [31:0] rdata,
                                input logic e_mreq, input logic [31:0] e_addr,
                                input logic [1:0] e_gnt, input logic [1:0] e_rv,
                                input int e_outst);
        vec_t v;
        v.req = req; v.gnt = gnt; v.rv = rv; v.err = err; v.rdata = rdata;
        v.e_mreq = e_mreq; v.e_addr = e_addr; v.e_gnt = e_gnt; v.e_rv = e_rv;
        v.e_outst = CNT_W'(e_outst);
        vecs.push_back(v);
    endfunction

    // Reference model state for the random phase
    int         m_q[$];
    int         m_rr;
    bit         m_lock;
    int         m_lidx;
    bit         m_proto;
    logic [31:0] r_addr [N_REQ];
    logic [31:0] r_wdata[N_REQ];
    logic [3:0]  r_be   [N_REQ];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        drive(2'b11, 1'b1, 1'b1, 1'b0, 32'h0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_mreq",   m_req_o,     0);
        check("rst_gnt",    s_gnt_o,     0);
        check("rst_rvalid", s_rvalid_o,  0);
        check("rst_outst",  outst_o,     0);
        check("rst_proto",  proto_err_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'b00, 1'b0, 1'b0, 1'b0, 32'h0);

        // Alternating grants, one-cycle responses
        add(2'b11, 1, 0, 0, 32'h0,          1, 32'h100, 2'b01, 2'b00, 0);
        add(2'b11, 1, 1, 0, 32'h1111_0000,  1, 32'h200, 2'b10, 2'b01, 1);
        add(2'b11, 1, 1, 0, 32'h2222_0000,  1, 32'h100, 2'b01, 2'b10, 1);
        add(2'b11, 1, 1, 0, 32'h3333_0000,  1, 32'h200, 2'b10, 2'b01, 1);
        add(2'b00, 0, 1, 1, 32'hDEAD_BEEF,  0, 32'h0,   2'b00, 2'b10, 1);
        // Lock on req0 for three ungranted cycles
        add(2'b11, 0, 0, 0, 32'h0,          1, 32'h100, 2'b00, 2'b00, 0);
        add(2'b11, 0, 0, 0, 32'h0,          1, 32'h100, 2'b00, 2'b00, 0);
        add(2'b11, 0, 0, 0, 32'h0,          1, 32'h100, 2'b00, 2'b00, 0);
        add(2'b11, 1, 0, 0, 32'h0,          1, 32'h100, 2'b01, 2'b00, 0);
        add(2'b11, 1, 0, 0, 32'h0,          1, 32'h200, 2'b10, 2'b00, 1);
        // FIFO full: held off, then one response frees a slot
        add(2'b11, 1, 0, 0, 32'h0,          0, 32'h100, 2'b00, 2'b00, 2);
        add(2'b11, 1, 1, 0, 32'h0,          0, 32'h100, 2'b00, 2'b01, 2);
        add(2'b11, 1, 0, 0, 32'h0,          1, 32'h100, 2'b01, 2'b00, 1);
        // Drain req1's response, then same-cycle grant req1 / respond req0
        add(2'b10, 0, 1, 0, 32'h0,          0, 32'h200, 2'b00, 2'b10, 2);
        add(2'b10, 1, 1, 0, 32'h5555_AAAA,  1, 32'h200, 2'b10, 2'b01, 1);
        add(2'b00, 0, 0, 0, 32'h0,          0, 32'h0,   2'b00, 2'b00, 1);
        add(2'b00, 0, 1, 0, 32'h0,          0, 32'h0,   2'b00, 2'b10, 1);
        add(2'b00, 0, 0, 0, 32'h0,          0, 32'h0,   2'b00, 2'b00, 0);
        // Locked requester drops its request: lock still holds
        add(2'b01, 0, 0, 0, 32'h0,          1, 32'h100, 2'b00, 2'b00, 0);
        add(2'b00, 0, 0, 0, 32'h0,          1, 32'h100, 2'b00, 2'b00, 0);
        add(2'b10, 1, 0, 0, 32'h0,          1, 32'h100, 2'b01, 2'b00, 0);
        add(2'b00, 0, 1, 0, 32'h0,          0, 32'h0,   2'b00, 2'b01, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].req, vecs[i].gnt, vecs[i].rv, vecs[i].err, vecs[i].rdata);
            #1;
            check($sformatf("v%0d_mreq", i),   m_req_o,    vecs[i].e_mreq);
            check($sformatf("v%0d_addr", i),   m_addr_o,   vecs[i].e_addr);
            check($sformatf("v%0d_gnt", i),    s_gnt_o,    vecs[i].e_gnt);
            check($sformatf("v%0d_rvalid", i), s_rvalid_o, vecs[i].e_rv);
            check($sformatf("v%0d_outst", i),  outst_o,    vecs[i].e_outst);
            check($sformatf("v%0d_err", i),    s_err_o,    vecs[i].err);
            check($sformatf("v%0d_rdata", i),  s_rdata_o,  vecs[i].rdata);
        end

        // Response while idle sets the sticky protocol error
        @(negedge clk);
        drive(2'b00, 0, 1, 0, 32'h0);
        #1;
        check("idle_rv_rvalid", s_rvalid_o,  0);
        check("idle_rv_proto0", proto_err_o, 0);
        @(negedge clk);
        drive(2'b00, 0, 0, 0, 32'h0);
        #1;
        check("idle_rv_proto1", proto_err_o, 1);
        repeat (3) @(negedge clk);
        #1;
        check("proto_sticky", proto_err_o, 1);

        // Reset in the middle of a burst with requests still asserted
        @(negedge clk);
        drive(2'b11, 1, 0, 0, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        check("burst_outst", outst_o, 2);
        rst_n = 1'b0;
        #1;
        check("midrst_outst", outst_o,     0);
        check("midrst_mreq",  m_req_o,     0);
        check("midrst_proto", proto_err_o, 0);
        check("midrst_gnt",   s_gnt_o,     0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(2'b00, 0, 0, 0, 32'h0);
        @(negedge clk);
        drive(2'b00, 0, 1, 0, 32'h0);
        #1;
        check("stale_rv_rvalid", s_rvalid_o, 0);
        @(negedge clk);
        drive(2'b00, 0, 0, 0, 32'h0);
        #1;
        check("stale_rv_proto", proto_err_o, 1);

        // Randomized phase against the reference model
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_q.delete();
        m_rr = 0; m_lock = 0; m_lidx = 0; m_proto = 0;

        for (int c = 0; c < 600; c++) begin
            int          win;
            bit          any, mreq, gnt, rvq;
            logic [1:0]  e_gnt, e_rv;
            @(negedge clk);
            for (int k = 0; k < N_REQ; k++) begin
                r_addr[k]  = $urandom;
                r_wdata[k] = $urandom;
                r_be[k]    = 4'($urandom_range(0, 15));
                s_addr_i[32*k +: 32]  = r_addr[k];
                s_wdata_i[32*k +: 32] = r_wdata[k];
                s_be_i[4*k +: 4]      = r_be[k];
            end
            s_req_i    = 2'($urandom_range(0, 3));
            s_we_i     = 2'($urandom_range(0, 3));
            m_gnt_i    = 1'($urandom_range(0, 1));
            m_rvalid_i = (m_q.size() > 0) ? ($urandom_range(0, 2) != 0)
                                          : ($urandom_range(0, 59) == 0);
            m_err_i    = 1'($urandom_range(0, 1));
            m_rdata_i  = $urandom;

            win = -1;
            if (m_lock) begin
                win = m_lidx;
            end else begin
                for (int i = 0; i < N_REQ; i++) begin
                    int k;
                    k = (m_rr + i) % N_REQ;
                    if (s_req_i[k]) begin
                        win = k;
                        break;
                    end
                end
            end
            any  = m_lock || (s_req_i != 0);
            mreq = any && (m_q.size() < MAX_OUTST);
            gnt  = mreq && m_gnt_i;
            e_gnt = '0;
            if (gnt) e_gnt[win] = 1'b1;
            rvq  = m_rvalid_i && (m_q.size() > 0);
            e_rv = '0;
            if (rvq) e_rv[m_q[0]] = 1'b1;

            #1;
            check($sformatf("r%0d_mreq", c),   m_req_o,    mreq);
            check($sformatf("r%0d_gnt", c),    s_gnt_o,    e_gnt);
            check($sformatf("r%0d_rvalid", c), s_rvalid_o, e_rv);
            check($sformatf("r%0d_outst", c),  outst_o,    m_q.size());
            check($sformatf("r%0d_proto", c),  proto_err_o, m_proto);
            check($sformatf("r%0d_addr", c),   m_addr_o,  (win >= 0) ? r_addr[win]  : 32'h0);
            check($sformatf("r%0d_wdata", c),  m_wdata_o, (win >= 0) ? r_wdata[win] : 32'h0);
            check($sformatf("r%0d_be", c),     m_be_o,    (win >= 0) ? r_be[win]    : 4'h0);
            check($sformatf("r%0d_we", c),     m_we_o,    (win >= 0) ? s_we_i[win]  : 1'b0);
            check($sformatf("r%0d_rdata", c),  s_rdata_o, m_rdata_i);
            check($sformatf("r%0d_err", c),    s_err_o,   m_err_i);

            if (m_rvalid_i && m_q.size() == 0) m_proto = 1;
            if (rvq) void'(m_q.pop_front());
            if (gnt) begin
                m_q.push_back(win);
                m_rr   = (win + 1) % N_REQ;
                m_lock = 0;
            end else if (mreq) begin
                m_lock = 1;
                m_lidx = win;
            end
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
